// File: rtl/vco.sv
// Digital VCO for the BTLE GFSK transmit chain: accumulates signed frequency
// words into a phase register and looks up cos/sin from run-time-loaded tables.
module vco #(
    parameter int VCO_BIT_WIDTH          = 16,
    parameter int SIN_COS_ADDR_BIT_WIDTH = 11,
    parameter int IQ_BIT_WIDTH           = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   cos_table_write_address,
    input  logic signed [IQ_BIT_WIDTH-1:0]      cos_table_write_data,
    input  logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   sin_table_write_address,
    input  logic signed [IQ_BIT_WIDTH-1:0]      sin_table_write_data,
    input  logic signed [VCO_BIT_WIDTH-1:0]     voltage_signal,
    input  logic                                voltage_signal_valid,
    output logic signed [IQ_BIT_WIDTH-1:0]      cos_out,
    output logic signed [IQ_BIT_WIDTH-1:0]      sin_out,
    output logic                                sin_cos_out_valid
);

    localparam int TABLE_DEPTH = 1 << SIN_COS_ADDR_BIT_WIDTH;

    logic signed [IQ_BIT_WIDTH-1:0]      cos_table [TABLE_DEPTH];
    logic signed [IQ_BIT_WIDTH-1:0]      sin_table [TABLE_DEPTH];

    logic [VCO_BIT_WIDTH-1:0]            phase;
    logic                                phase_valid;
    logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   table_address;

    // Truncated upper phase bits of the already-updated phase.
    assign table_address = phase[VCO_BIT_WIDTH-1 -: SIN_COS_ADDR_BIT_WIDTH];

    // Table write ports run every cycle and are deliberately independent of reset.
    always_ff @(posedge clk) begin
        cos_table[cos_table_write_address] <= cos_table_write_data;
    end

    always_ff @(posedge clk) begin
        sin_table[sin_table_write_address] <= sin_table_write_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase       <= '0;
            phase_valid <= 1'b0;
        end else begin
            phase_valid <= voltage_signal_valid;
            if (voltage_signal_valid) begin
                phase <= phase + $unsigned(voltage_signal);
            end
        end
    end

    // The synchronous table read register doubles as the output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cos_out           <= '0;
            sin_out           <= '0;
            sin_cos_out_valid <= 1'b0;
        end else begin
            sin_cos_out_valid <= phase_valid;
            if (phase_valid) begin
                cos_out <= cos_table[table_address];
                sin_out <= sin_table[table_address];
            end
        end
    end

endmodule

// File: tb/tb_vco.sv
// Directed self-checking bench for vco: table load, cumulative phase
// addressing, wrap-around, full-rate streaming and mid-stream reset.
module tb_vco;

    localparam int VW = 16;
    localparam int AW = 11;
    localparam int IW = 8;
    localparam int DEPTH = 2048;
    localparam real PI = 3.14159265358979323846;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [AW-1:0]         cos_table_write_address;
    logic signed [IW-1:0]  cos_table_write_data;
    logic [AW-1:0]         sin_table_write_address;
    logic signed [IW-1:0]  sin_table_write_data;
    logic signed [VW-1:0]  voltage_signal;
    logic                  voltage_signal_valid;
    logic signed [IW-1:0]  cos_out;
    logic signed [IW-1:0]  sin_out;
    logic                  sin_cos_out_valid;

    int cos_tab [DEPTH];
    int sin_tab [DEPTH];
    int passed = 0;
    int total  = 0;

    vco #(
        .VCO_BIT_WIDTH(VW),
        .SIN_COS_ADDR_BIT_WIDTH(AW),
        .IQ_BIT_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cos_table_write_address(cos_table_write_address),
        .cos_table_write_data(cos_table_write_data),
        .sin_table_write_address(sin_table_write_address),
        .sin_table_write_data(sin_table_write_data),
        .voltage_signal(voltage_signal),
        .voltage_signal_valid(voltage_signal_valid),
        .cos_out(cos_out),
        .sin_out(sin_out),
        .sin_cos_out_valid(sin_cos_out_valid)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else return -$rtoi(-x + 0.5);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sample on alternate cycles: no strobe right after acceptance,
    // strobe with the expected pair exactly two edges after acceptance.
    task automatic send_alt(input int v, input int ec, input int es, input string name);
        voltage_signal = VW'(v);
        voltage_signal_valid = 1'b1;
        step();
        total++;
        if (sin_cos_out_valid !== 1'b0)
            $display("FAIL %s early_valid: got %b expected 0", name, sin_cos_out_valid);
        else passed++;
        voltage_signal_valid = 1'b0;
        step();
        total++;
        if (sin_cos_out_valid !== 1'b1 || cos_out !== IW'(ec) || sin_out !== IW'(es))
            $display("FAIL %s: got valid=%b cos=%0d sin=%0d expected valid=1 cos=%0d sin=%0d",
                     name, sin_cos_out_valid, cos_out, sin_out, ec, es);
        else passed++;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        voltage_signal_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        voltage_signal = '0;
        voltage_signal_valid = 1'b1;
        cos_table_write_address = '0;
        cos_table_write_data = '0;
        sin_table_write_address = '0;
        sin_table_write_data = '0;
        step();
        step();
        total++;
        if (cos_out !== '0 || sin_out !== '0 || sin_cos_out_valid !== 1'b0)
            $display("FAIL reset: got cos=%0d sin=%0d valid=%b expected 0 0 0",
                     cos_out, sin_out, sin_cos_out_valid);
        else passed++;
        voltage_signal_valid = 1'b0;
    endtask

    // Loaded while rst is still low: table writes ignore reset.
    task automatic load_tables();
        for (int i = 0; i < DEPTH; i++) begin
            cos_tab[i] = rnd(127.0 * $cos(2.0 * PI * i / DEPTH));
            sin_tab[i] = rnd(127.0 * $sin(2.0 * PI * i / DEPTH));
        end
        for (int i = 0; i < DEPTH; i++) begin
            cos_table_write_address = AW'(i);
            cos_table_write_data    = IW'(cos_tab[i]);
            sin_table_write_address = AW'(i);
            sin_table_write_data    = IW'(sin_tab[i]);
            step();
        end
        total++;
        if (sin_cos_out_valid !== 1'b0)
            $display("FAIL load_valid: got %b expected 0", sin_cos_out_valid);
        else passed++;
        rst = 1'b1;
    endtask

    task automatic test_zero();
        for (int k = 0; k < 10; k++) send_alt(0, 127, 0, "zero");
    endtask

    task automatic test_ramp();
        reset_dut();
        for (int k = 0; k < 16; k++) send_alt(32, cos_tab[k+1], sin_tab[k+1], "ramp");
        step();
        total++;
        if (sin_cos_out_valid !== 1'b0 || cos_out !== IW'(cos_tab[16]) || sin_out !== IW'(sin_tab[16]))
            $display("FAIL hold: got valid=%b cos=%0d sin=%0d expected valid=0 cos=%0d sin=%0d",
                     sin_cos_out_valid, cos_out, sin_out, cos_tab[16], sin_tab[16]);
        else passed++;
    endtask

    task automatic test_wrap_under();
        reset_dut();
        // table[2047]: 127*cos(-2pi/2048) -> 127, 127*sin(-2pi/2048) = -0.39 -> 0
        send_alt(-32, 127, 0, "wrap_under");
        send_alt(-32, cos_tab[2046], sin_tab[2046], "wrap_under2");
    endtask

    task automatic test_wrap_over();
        int ec [4] = '{0, -127, 0, 127};
        int es [4] = '{127, 0, -127, 0};
        reset_dut();
        for (int k = 0; k < 4; k++) send_alt(16384, ec[k], es[k], "wrap_over");
    endtask

    task automatic test_back_to_back();
        int outs = 0;
        reset_dut();
        voltage_signal = VW'(32);
        for (int t = 0; t < 104; t++) begin
            voltage_signal_valid = (t < 100);
            step();
            if (sin_cos_out_valid === 1'b1) outs++;
            total++;
            if (sin_cos_out_valid !== (t >= 1 && t <= 100))
                $display("FAIL b2b_valid t=%0d: got %b expected %b",
                         t, sin_cos_out_valid, (t >= 1 && t <= 100));
            else if (t >= 1 && t <= 100 && (cos_out !== IW'(cos_tab[t]) || sin_out !== IW'(sin_tab[t])))
                $display("FAIL b2b_data t=%0d: got cos=%0d sin=%0d expected cos=%0d sin=%0d",
                         t, cos_out, sin_out, cos_tab[t], sin_tab[t]);
            else passed++;
        end
        total++;
        if (outs != 100)
            $display("FAIL b2b_count: got %0d expected 100", outs);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        reset_dut();
        voltage_signal = VW'(32);
        voltage_signal_valid = 1'b1;
        step();
        step();
        total++;
        if (sin_cos_out_valid !== 1'b1 || cos_out !== IW'(cos_tab[1]))
            $display("FAIL mid_pre: got valid=%b cos=%0d expected valid=1 cos=%0d",
                     sin_cos_out_valid, cos_out, cos_tab[1]);
        else passed++;
        rst = 1'b0;
        voltage_signal_valid = 1'b0;
        step();
        total++;
        if (cos_out !== '0 || sin_out !== '0 || sin_cos_out_valid !== 1'b0)
            $display("FAIL mid_reset: got cos=%0d sin=%0d valid=%b expected 0 0 0",
                     cos_out, sin_out, sin_cos_out_valid);
        else passed++;
        rst = 1'b1;
        step();
        total++;
        if (sin_cos_out_valid !== 1'b0)
            $display("FAIL mid_discard: got %b expected 0", sin_cos_out_valid);
        else passed++;
        send_alt(32, cos_tab[1], sin_tab[1], "mid_restart");
    endtask

    initial begin
        test_reset();
        load_tables();
        test_zero();
        test_ramp();
        test_wrap_under();
        test_wrap_over();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
